mem_wb_pipe_stage: RTL and testbench
====================================

// Module: mem_wb_pipe_stage
// PURPOSE
//  Parametrised MEM->WB pipeline stage; successor to the plain MEM/WB latch.
//  Adds valid/ready handshake with a 2-entry skid buffer, synchronous flush,
//  a write-back data mux, x0 write suppression and a retired-instruction counter.
//  Sits between the data-memory stage and the register-file write port.
// PARAMETERS
//  XLEN        64  data width of ReadData / ALU_result / wb_data
//  REG_AW      5   register-index width (rd)
//  CNT_W       32  width of retired-instruction counter (saturating)
// PORTS
//  clk              in   1       clock; all state updates on rising edge
//  reset            in   1       asynchronous, active-high reset
//  flush            in   1       synchronous flush; drops all held and incoming entries
//  in_valid         in   1       MEM stage presents an entry
//  in_ready         out  1       stage can accept; = !skid_valid (registered state only)
//  RegWrite         in   1       entry writes a register
//  MemtoReg         in   1       1: write ReadData, 0: write ALU_result
//  ReadData         in   XLEN    load data from data memory
//  ALU_result       in   XLEN    ALU result / address
//  rd               in   REG_AW  destination register
//  out_valid        out  1       head entry valid toward WB
//  out_ready        in   1       WB accepts head entry
//  RegWrite_store   out  1       head RegWrite, forced 0 when rd_store==0 or !out_valid
//  MemtoReg_store   out  1       head MemtoReg
//  ReadData_store   out  XLEN    head ReadData
//  ALU_result_store out  XLEN    head ALU_result
//  rd_store         out  REG_AW  head rd
//  wb_data          out  XLEN    MemtoReg_store ? ReadData_store : ALU_result_store (comb.)
//  retired_cnt      out  CNT_W   count of entries with RegWrite_store=1 accepted by WB
// BEHAVIOUR
//  - Storage: head slot (drives *_store) + skid slot, each with a valid bit.
//  - Reset (async): both valid bits 0, all *_store fields 0, retired_cnt 0;
//    in_ready=1, out_valid=0, wb_data=0.
//  - Accept = in_valid & in_ready; retire = out_valid & out_ready.
//  - Latency: an accepted entry appears on *_store the next cycle when head is
//    empty or retiring in the same cycle; otherwise it goes to the skid slot.
//  - Retire with skid valid: skid moves to head; an accept in that cycle fills skid.
//  - Both slots full: in_ready=0; in_valid is ignored and the entry is not taken.
//  - Order strictly FIFO; no entry duplicated or lost except by flush.
//  - Head fields hold stable while out_valid & !out_ready.
//  - Field contents of an empty slot are don't-care, but RegWrite_store must be 0
//    whenever out_valid=0.
//  - flush=1: next cycle both valid bits are 0; a same-cycle accept is discarded;
//    a same-cycle retire still counts. Flush has priority over accept and shift.
//  - x0 rule: rd==0 entries travel normally, but RegWrite_store reads 0 and
//    they do not increment retired_cnt.
//  - retired_cnt: +1 on retire with RegWrite_store=1; saturates at 2^CNT_W-1;
//    unaffected by flush.
//  - Reset asserted mid-operation clears everything immediately (async), without
//    waiting for a clock edge.
// TESTING
//  1. Reset with in_valid=1 -> out_valid=0, in_ready=1, retired_cnt=0.
//     Release reset, push rd=3, ALU_result=0x10, MemtoReg=0, out_ready=1
//     -> next cycle out_valid=1, wb_data=0x10, RegWrite_store=1.
//  2. out_ready=0; push A(rd=1), B(rd=2), C(rd=4) on consecutive cycles
//     -> in_ready=0 after B; C not taken. Then out_ready=1 -> retire A, then B,
//     then empty; retired_cnt=2.
//  3. MemtoReg=1, ReadData=0xDEAD, ALU_result=0x8 -> wb_data=0xDEAD.
//  4. rd=0, RegWrite=1 -> out_valid=1, RegWrite_store=0; after retire,
//     retired_cnt is unchanged.
//  5. Both slots full, flush=1 with in_valid=1 -> next cycle out_valid=0,
//     in_ready=1, and no stale entry emerges later.
//  6. CNT_W=4: retire 17 writing entries -> retired_cnt=15 (saturated).
//     Assert reset mid-stream -> all outputs return to their reset values.

Source files
------------

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline stage with a valid/ready handshake, a 2-entry skid buffer, synchronous flush,
// a write-back data mux, x0 write suppression and a saturating retired-instruction counter.
module mem_wb_pipe_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [XLEN-1:0]   ReadData,
    input  logic [XLEN-1:0]   ALU_result,
    input  logic [REG_AW-1:0] rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              RegWrite_store,
    output logic              MemtoReg_store,
    output logic [XLEN-1:0]   ReadData_store,
    output logic [XLEN-1:0]   ALU_result_store,
    output logic [REG_AW-1:0] rd_store,
    output logic [XLEN-1:0]   wb_data,
    output logic [CNT_W-1:0]  retired_cnt
);

    logic              head_valid;
    logic              head_regwrite;
    logic              head_memtoreg;
    logic [XLEN-1:0]   head_readdata;
    logic [XLEN-1:0]   head_alu;
    logic [REG_AW-1:0] head_rd;

    logic              skid_valid;
    logic              skid_regwrite;
    logic              skid_memtoreg;
    logic [XLEN-1:0]   skid_readdata;
    logic [XLEN-1:0]   skid_alu;
    logic [REG_AW-1:0] skid_rd;

    logic accept;
    logic retire;

    assign in_ready  = !skid_valid;
    assign out_valid = head_valid;
    assign accept    = in_valid && in_ready;
    assign retire    = head_valid && out_ready;

    // Writes to x0 are carried through the stage but never reach the register file.
    assign RegWrite_store   = head_valid && head_regwrite && (head_rd != '0);
    assign MemtoReg_store   = head_memtoreg;
    assign ReadData_store   = head_readdata;
    assign ALU_result_store = head_alu;
    assign rd_store         = head_rd;
    assign wb_data          = head_memtoreg ? head_readdata : head_alu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_valid    <= 1'b0;
            head_regwrite <= 1'b0;
            head_memtoreg <= 1'b0;
            head_readdata <= '0;
            head_alu      <= '0;
            head_rd       <= '0;
            skid_valid    <= 1'b0;
            skid_regwrite <= 1'b0;
            skid_memtoreg <= 1'b0;
            skid_readdata <= '0;
            skid_alu      <= '0;
            skid_rd       <= '0;
        end else if (flush) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (retire && skid_valid) begin
            head_valid    <= 1'b1;
            head_regwrite <= skid_regwrite;
            head_memtoreg <= skid_memtoreg;
            head_readdata <= skid_readdata;
            head_alu      <= skid_alu;
            head_rd       <= skid_rd;
            skid_valid    <= accept;
            if (accept) begin
                skid_regwrite <= RegWrite;
                skid_memtoreg <= MemtoReg;
                skid_readdata <= ReadData;
                skid_alu      <= ALU_result;
                skid_rd       <= rd;
            end
        end else if (retire || !head_valid) begin
            // Head is free this cycle: a new entry bypasses the skid slot.
            head_valid <= accept;
            if (accept) begin
                head_regwrite <= RegWrite;
                head_memtoreg <= MemtoReg;
                head_readdata <= ReadData;
                head_alu      <= ALU_result;
                head_rd       <= rd;
            end
        end else if (accept) begin
            skid_valid    <= 1'b1;
            skid_regwrite <= RegWrite;
            skid_memtoreg <= MemtoReg;
            skid_readdata <= ReadData;
            skid_alu      <= ALU_result;
            skid_rd       <= rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt <= '0;
        end else if (retire && RegWrite_store && (retired_cnt != '1)) begin
            retired_cnt <= retired_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Directed self-checking bench for mem_wb_pipe_stage (CNT_W=4 so saturation is reachable).
module tb_mem_wb_pipe_stage;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              RegWrite;
    logic              MemtoReg;
    logic [XLEN-1:0]   ReadData;
    logic [XLEN-1:0]   ALU_result;
    logic [REG_AW-1:0] rd;
    logic              out_valid;
    logic              out_ready;
    logic              RegWrite_store;
    logic              MemtoReg_store;
    logic [XLEN-1:0]   ReadData_store;
    logic [XLEN-1:0]   ALU_result_store;
    logic [REG_AW-1:0] rd_store;
    logic [XLEN-1:0]   wb_data;
    logic [CNT_W-1:0]  retired_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [CNT_W-1:0] exp_cnt;

    always #5 clk = ~clk;

    mem_wb_pipe_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ReadData(ReadData),
        .ALU_result(ALU_result), .rd(rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .RegWrite_store(RegWrite_store), .MemtoReg_store(MemtoReg_store),
        .ReadData_store(ReadData_store), .ALU_result_store(ALU_result_store),
        .rd_store(rd_store), .wb_data(wb_data), .retired_cnt(retired_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [XLEN-1:0] rdata, input logic [XLEN-1:0] alu,
                         input logic [REG_AW-1:0] r);
        in_valid   = v;
        RegWrite   = rw;
        MemtoReg   = m2r;
        ReadData   = rdata;
        ALU_result = alu;
        rd         = r;
    endtask

    task automatic test_reset();
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 64'h0, 64'h10, 5'd3);
        reset = 1'b1;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (retired_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", retired_cnt); end
        n_cmp++; if (wb_data !== 64'h0) begin n_bad++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_hold_out_valid got=%b exp=0", out_valid); end
        reset = 1'b0;
        exp_cnt = '0;
        step();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL first_out_valid got=%b exp=1", out_valid); end
        n_cmp++; if (wb_data !== 64'h10) begin n_bad++; $display("FAIL first_wb_data got=%h exp=10", wb_data); end
        n_cmp++; if (RegWrite_store !== 1'b1) begin n_bad++; $display("FAIL first_regwrite got=%b exp=1", RegWrite_store); end
        n_cmp++; if (rd_store !== 5'd3) begin n_bad++; $display("FAIL first_rd got=%0d exp=3", rd_store); end
        in_valid = 1'b0;
        step();
        exp_cnt = 4'd1;
        n_cmp++; if (retired_cnt !== exp_cnt) begin n_bad++; $display("FAIL first_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL first_empty got=%b exp=0", out_valid); end
        n_cmp++; if (RegWrite_store !== 1'b0) begin n_bad++; $display("FAIL empty_regwrite got=%b exp=0", RegWrite_store); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 64'h0, 64'h100, 5'd1);
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_a got=%b exp=1", in_ready); end
        drive(1'b1, 1'b1, 1'b0, 64'h0, 64'h200, 5'd2);
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_b got=%b exp=0", in_ready); end
        drive(1'b1, 1'b1, 1'b0, 64'h0, 64'h400, 5'd4);
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_c got=%b exp=0", in_ready); end
        n_cmp++; if (rd_store !== 5'd1) begin n_bad++; $display("FAIL bp_head_stable got=%0d exp=1", rd_store); end
        n_cmp++; if (ALU_result_store !== 64'h100) begin n_bad++; $display("FAIL bp_head_alu got=%h exp=100", ALU_result_store); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        exp_cnt = exp_cnt + 1'b1;
        n_cmp++; if (rd_store !== 5'd2 || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_second rd=%0d v=%b exp rd=2 v=1", rd_store, out_valid); end
        n_cmp++; if (ALU_result_store !== 64'h200) begin n_bad++; $display("FAIL bp_second_alu got=%h exp=200", ALU_result_store); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after got=%b exp=1", in_ready); end
        step();
        exp_cnt = exp_cnt + 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got=%b exp=0 (C must not be taken)", out_valid); end
        n_cmp++; if (retired_cnt !== exp_cnt) begin n_bad++; $display("FAIL bp_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); end
    endtask

    task automatic test_wb_mux();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 64'hDEAD, 64'h8, 5'd5);
        step();
        in_valid = 1'b0;
        n_cmp++; if (wb_data !== 64'hDEAD) begin n_bad++; $display("FAIL mux_load got=%h exp=dead", wb_data); end
        n_cmp++; if (MemtoReg_store !== 1'b1 || ReadData_store !== 64'hDEAD) begin n_bad++; $display("FAIL mux_fields m2r=%b rdata=%h exp 1/dead", MemtoReg_store, ReadData_store); end
        out_ready = 1'b1;
        step();
        exp_cnt = exp_cnt + 1'b1;
        n_cmp++; if (retired_cnt !== exp_cnt) begin n_bad++; $display("FAIL mux_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); end
    endtask

    task automatic test_x0();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 64'h0, 64'h55, 5'd0);
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL x0_valid got=%b exp=1", out_valid); end
        n_cmp++; if (RegWrite_store !== 1'b0) begin n_bad++; $display("FAIL x0_regwrite got=%b exp=0", RegWrite_store); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (retired_cnt !== exp_cnt) begin n_bad++; $display("FAIL x0_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL x0_retired got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 64'h0, 64'h60, 5'd6);
        step();
        drive(1'b1, 1'b1, 1'b0, 64'h0, 64'h70, 5'd7);
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_full got=%b exp=0", in_ready); end
        drive(1'b1, 1'b1, 1'b0, 64'h0, 64'h80, 5'd8);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_stale cyc=%0d got=%b exp=0", i, out_valid); end
        end
        n_cmp++; if (retired_cnt !== exp_cnt) begin n_bad++; $display("FAIL flush_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); end
        // A retire in the flush cycle still counts.
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 64'h0, 64'h90, 5'd9);
        step();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
        n_cmp++; if (retired_cnt !== exp_cnt) begin n_bad++; $display("FAIL flush_retire_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_retire_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 1'b0, 64'h0, 64'(i + 1), 5'(i % 31 + 1));
            step();
            n_cmp++; if (out_valid !== 1'b1 || ALU_result_store !== 64'(i + 1)) begin
                n_bad++; $display("FAIL b2b_stream i=%0d v=%b alu=%h exp v=1 alu=%h", i, out_valid, ALU_result_store, 64'(i + 1));
            end
        end
        in_valid = 1'b0;
        step();
        exp_cnt = 4'd15;
        n_cmp++; if (retired_cnt !== exp_cnt) begin n_bad++; $display("FAIL sat_cnt got=%0d exp=%0d", retired_cnt, exp_cnt); end
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 64'hAB, 64'hCD, 5'd12);
        step();
        step();
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_full rdy=%b v=%b exp 0/1", in_ready, out_valid); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL async_reset_hs v=%b rdy=%b exp 0/1", out_valid, in_ready); end
        n_cmp++; if (retired_cnt !== 4'd0) begin n_bad++; $display("FAIL async_reset_cnt got=%0d exp=0", retired_cnt); end
        n_cmp++; if (wb_data !== 64'h0 || rd_store !== 5'd0 || RegWrite_store !== 1'b0 || MemtoReg_store !== 1'b0) begin
            n_bad++; $display("FAIL async_reset_fields wb=%h rd=%0d rw=%b m2r=%b exp all 0", wb_data, rd_store, RegWrite_store, MemtoReg_store);
        end
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_empty got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_wb_mux();
        test_x0();
        test_flush();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
